// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // Controller FSM states.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_e;

  // Register r0 is hard-wired to zero, so it never carries a dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in ID/EX whose destination is read by decode.
// Latency: combinational, same cycle.
// Backpressure: none; the result is consumed by the stall controller.
//
// Ports:
//   ID_RS, ID_RT  source fields of the decode instruction
//   ID_USES_RT    decode really reads rt (otherwise rt is a destination/immediate)
//   EX_MEMREAD    ID/EX holds a load
//   EX_RT         load destination register
//   hazard        decode must wait one cycle for the load data
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ID_RS,
  input  logic [4:0] ID_RT,
  input  logic       ID_USES_RT,
  input  logic       EX_MEMREAD,
  input  logic [4:0] EX_RT,
  output logic       hazard
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = (EX_RT == ID_RS);
    rt_match = ID_USES_RT && (EX_RT == ID_RT);
    hazard   = EX_MEMREAD && (EX_RT != REG_ZERO) && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline with memory-timeout fault.
// Latency: all control outputs are combinational (Mealy); state/counters update on CLK.
// Backpressure: DMEM_READY low holds ID/EX..MEM/WB and freezes PC and IF/ID.
//
// Ports:
//   CLK, RESET                      clock, synchronous active-high reset
//   ID_*, EX_MEMREAD, EX_RT         load-use hazard inputs
//   MEM_ACCESS, MEM_BRANCH_TAKEN    EX/MEM stage status
//   DMEM_READY / DMEM_REQ           data-memory handshake
//   PC_WRITE, IFID_WRITE            front-end advance enables
//   IFID/IDEX/EXMEM_FLUSH           bubble insertion
//   PIPE_HOLD                       back-end hold
//   MEM_FAULT                       sticky timeout indication
//   STALL_CYCLES                    saturating count of cycles with PC_WRITE=0
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       ID_RS,
  input  logic [4:0]       ID_RT,
  input  logic             ID_USES_RT,
  input  logic             EX_MEMREAD,
  input  logic [4:0]       EX_RT,
  input  logic             MEM_ACCESS,
  input  logic             MEM_BRANCH_TAKEN,
  input  logic             DMEM_READY,
  output logic             DMEM_REQ,
  output logic             PC_WRITE,
  output logic             IFID_WRITE,
  output logic             IFID_FLUSH,
  output logic             IDEX_FLUSH,
  output logic             EXMEM_FLUSH,
  output logic             PIPE_HOLD,
  output logic             MEM_FAULT,
  output logic [CNT_W-1:0] STALL_CYCLES
);

  localparam int               WC_W    = $clog2(TIMEOUT);
  localparam logic [WC_W-1:0]  WC_ONE  = WC_W'(1);
  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wcnt_q,  wcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             hazard;

  load_use_detect u_load_use_detect (
    .ID_RS      (ID_RS),
    .ID_RT      (ID_RT),
    .ID_USES_RT (ID_USES_RT),
    .EX_MEMREAD (EX_MEMREAD),
    .EX_RT      (EX_RT),
    .hazard     (hazard)
  );

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    stall_d     = stall_q;
    DMEM_REQ    = 1'b0;
    PC_WRITE    = 1'b0;
    IFID_WRITE  = 1'b0;
    IFID_FLUSH  = 1'b0;
    IDEX_FLUSH  = 1'b0;
    EXMEM_FLUSH = 1'b0;
    PIPE_HOLD   = 1'b0;

    // While RESET is high every control output stays at its quiet value;
    // the register clear itself happens in the sequential block.
    if (!RESET) begin
      unique case (state_q)
        RUN: begin
          DMEM_REQ = MEM_ACCESS;
          wcnt_d   = '0;
          if (MEM_ACCESS && !DMEM_READY) begin
            // The first wait cycle is spent here, so MEM_WAIT starts at 1.
            PIPE_HOLD = 1'b1;
            state_d   = MEM_WAIT;
            wcnt_d    = WC_ONE;
          end else if (MEM_BRANCH_TAKEN) begin
            // Squash the three younger slots; the redirected PC loads now.
            // Any load-use hazard belongs to a squashed instruction.
            IFID_FLUSH  = 1'b1;
            IDEX_FLUSH  = 1'b1;
            EXMEM_FLUSH = 1'b1;
            PC_WRITE    = 1'b1;
            IFID_WRITE  = 1'b1;
          end else if (hazard) begin
            IDEX_FLUSH = 1'b1;
          end else begin
            PC_WRITE   = 1'b1;
            IFID_WRITE = 1'b1;
          end
        end
        MEM_WAIT: begin
          DMEM_REQ = MEM_ACCESS;
          if (DMEM_READY) begin
            PC_WRITE   = 1'b1;
            IFID_WRITE = 1'b1;
            state_d    = RUN;
            wcnt_d     = '0;
          end else begin
            PIPE_HOLD = 1'b1;
            if (wcnt_q == WC_LAST) begin
              state_d = FAULT;
            end else begin
              wcnt_d = wcnt_q + WC_ONE;
            end
          end
        end
        FAULT: begin
          PIPE_HOLD = 1'b1;
        end
        default: begin
          state_d = RUN;
          wcnt_d  = '0;
        end
      endcase

      if ((state_q == RUN || state_q == MEM_WAIT) && !PC_WRITE &&
          (stall_q != CNT_MAX)) begin
        stall_d = stall_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      stall_q <= stall_d;
    end
  end

  // FAULT is only left through reset, so the state itself is the sticky flag.
  assign MEM_FAULT    = !RESET && (state_q == FAULT);
  assign STALL_CYCLES = stall_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 64-bit five-stage pipeline. Each cycle it decides whether the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers advance, hold or are squashed. It detects load-use hazards, branches resolved in MEM and wait-stated data-memory accesses. It also provides a memory-timeout fault and a saturating stall-cycle counter.

## Interface
- TIMEOUT, 16: maximum consecutive wait cycles for a data-memory access before fault (≥2).
- CNT_W, 16: width of the stall-cycle counter.

- CLK  in  1  single clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- ID_RS  in  5  rs field of the instruction in decode.
- ID_RT  in  5  rt field of the instruction in decode.
- ID_USES_RT  in  1  decode instruction reads rt as a source.
- EX_MEMREAD  in  1  instruction in ID/EX is a load.
- EX_RT  in  5  destination register of the instruction in ID/EX.
- MEM_ACCESS  in  1  EX/MEM holds a load or store (MEMREAD_OUT | MEMWRITE_OUT).
- MEM_BRANCH_TAKEN  in  1  EX/MEM holds a taken branch (BRANCH_ZERO_OUT & ZERO_OUT).
- DMEM_READY  in  1  data memory completes the current access this cycle.
- DMEM_REQ  out  1  data-memory access request.
- PC_WRITE  out  1  PC may load its next value.
- IFID_WRITE  out  1  IF/ID may load.
- IFID_FLUSH  out  1  IF/ID loads a bubble.
- IDEX_FLUSH  out  1  ID/EX loads a bubble (all control bits 0).
- EXMEM_FLUSH  out  1  EX/MEM loads a bubble.
- PIPE_HOLD  out  1  ID/EX, EX/MEM and MEM/WB keep their current contents.
- MEM_FAULT  out  1  sticky memory-timeout indication.
- STALL_CYCLES  out  CNT_W  saturating count of stalled cycles.

## Operation
- FSM states: RUN, MEM_WAIT, FAULT. Reset state is RUN.
- Wait counter `wcnt` has width clog2(TIMEOUT). It is cleared in RUN.
- Priority within RUN: memory stall > taken branch > load-use > normal.
- DMEM_REQ = MEM_ACCESS in RUN or MEM_WAIT; 0 in FAULT.
- **RUN, MEM_ACCESS & !DMEM_READY**
  - PIPE_HOLD=1, PC_WRITE=0, IFID_WRITE=0, all flushes 0.
  - Next state MEM_WAIT; wcnt←1.
- **RUN, MEM_ACCESS & DMEM_READY**
  - Zero-wait access; treated as normal.
- **RUN, MEM_BRANCH_TAKEN (no memory stall)**
  - IFID_FLUSH=IDEX_FLUSH=EXMEM_FLUSH=1, PC_WRITE=1, IFID_WRITE=1.
  - Load-use detection is suppressed this cycle.
- **RUN, load-use hazard**
  - Condition: EX_MEMREAD & EX_RT≠0 & (EX_RT==ID_RS | (ID_USES_RT & EX_RT==ID_RT)).
  - Response: PC_WRITE=0, IFID_WRITE=0, IDEX_FLUSH=1.
  - Lasts exactly one cycle; the load then leaves ID/EX.
- **RUN, normal**
  - PC_WRITE=1, IFID_WRITE=1, PIPE_HOLD=0, flushes 0.
- **MEM_WAIT**
  - While !DMEM_READY: PIPE_HOLD=1, PC_WRITE=0, IFID_WRITE=0, and wcnt increments.
  - DMEM_READY: outputs as RUN-normal (pipeline advances); next state RUN.
  - MEM_BRANCH_TAKEN and the load-use check are ignored in this state.
  - wcnt==TIMEOUT-1 & !DMEM_READY: next state FAULT.
- **FAULT**
  - PIPE_HOLD=1, PC_WRITE=0, IFID_WRITE=0, DMEM_REQ=0, MEM_FAULT=1.
  - Stays in FAULT until RESET.
- **STALL_CYCLES**
  - Increments on each non-reset cycle in RUN or MEM_WAIT where PC_WRITE=0.
  - Saturates at 2^CNT_W-1; does not count in FAULT.

## Timing
- All outputs are combinational functions of the current state and inputs (Mealy), valid in the same cycle.
- State, wcnt, MEM_FAULT and STALL_CYCLES update on the rising edge of CLK.
- While RESET=1, outputs are forced: PC_WRITE=0, IFID_WRITE=0, PIPE_HOLD=0, all flushes 0, DMEM_REQ=0, MEM_FAULT=0.
- The first edge with RESET=1 sets state=RUN, wcnt=0, STALL_CYCLES=0.
- RESET asserted in MEM_WAIT or FAULT returns the FSM to RUN at the next edge, with no pending request.
- Load-use stall costs 1 cycle. A taken branch costs 3 squashed slots and 0 extra stall cycles. A memory access costs N stall cycles for N wait cycles.
- Maximum MEM_WAIT dwell is TIMEOUT-1 cycles before FAULT.

## Structure
- Package `pipe_ctrl_pkg` holds the state enum (RUN, MEM_WAIT, FAULT) and the `REG_ZERO` constant (5'd0).
- One combinational sub-module, `load_use_detect`: inputs ID_RS, ID_RT, ID_USES_RT, EX_MEMREAD, EX_RT; output `hazard`.
- The FSM, wait counter and stall counter live in the top module.

## Test plan
- Load r5 in EX, decode reads rs=5 → one cycle of PC_WRITE=0, IFID_WRITE=0, IDEX_FLUSH=1; STALL_CYCLES 0→1. Repeat with EX_RT=0 → no stall.
- MEM_ACCESS with DMEM_READY low for 3 cycles, then high → PIPE_HOLD=1 for 3 cycles, advance on the 4th cycle; STALL_CYCLES +3; state returns to RUN.
- MEM_BRANCH_TAKEN=1 with a simultaneous load-use hazard → all three flushes =1, PC_WRITE=1, IDEX_FLUSH is not a stall, STALL_CYCLES unchanged.
- TIMEOUT=4, DMEM_READY held low → FAULT entered after the 4th stalled cycle; MEM_FAULT=1 and DMEM_REQ=0 persist; RESET for one cycle → RUN with all counters 0.
- CNT_W=4, 20 consecutive stall cycles → STALL_CYCLES holds at 15.
